// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared forward-select and multiply-tracker types
package hazard_scoreboard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10, FWD_MUL = 2'b11} fwd_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
endpackage

// File: rtl/hazard_scoreboard_mul_tracker.sv
// mul_tracker: tracks the single outstanding multiply and its destination register
module mul_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mul_e,
  input  logic [REG_AW-1:0]      rd_e,
  input  logic                   regWrite_W,
  output state_e                 state,
  output logic [2**REG_AW-1:0]   pending,
  output logic [REG_AW-1:0]      mul_rd,
  output logic                   mul_wb
);
  localparam int NREGS = 2**REG_AW;
  state_e state_n;
  logic [3:0] cnt_q, cnt_n;
  // next state: the writeback waits in DONE while the W stage owns the register-file port
  always_comb begin
    state_n = state;
    cnt_n = cnt_q;
    mul_wb = 1'b0;
    case (state)
      IDLE: if (mul_e) begin
        state_n = BUSY;
        cnt_n = 4'(MUL_LAT - 1);
      end
      BUSY: if (cnt_q == 4'd0) state_n = DONE;
            else cnt_n = cnt_q - 4'd1;
      DONE: if (!regWrite_W) begin
        mul_wb = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counter and the one-hot pending bit of the in-flight destination
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt_q <= '0;
      pending <= '0;
      mul_rd <= '0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
      if (state == IDLE && mul_e) begin
        mul_rd <= rd_e;
        pending <= NREGS'(1) << rd_e;
      end else if (mul_wb) pending <= '0;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, load-use/scoreboard stalls and branch flushes
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NSRC-1:0][REG_AW-1:0]  src_d,
  input  logic [NSRC-1:0][REG_AW-1:0]  src_e,
  input  logic [NSRC-1:0]              src_d_vld,
  input  logic [NSRC-1:0]              src_e_vld,
  input  logic [REG_AW-1:0]            rd_d,
  input  logic [REG_AW-1:0]            rd_e,
  input  logic [REG_AW-1:0]            rd_m,
  input  logic [REG_AW-1:0]            rd_w,
  input  logic                         regWrite_D,
  input  logic                         regWrite_M,
  input  logic                         regWrite_W,
  input  logic [1:0]                   resultSrc_E,
  input  logic                         mul_d,
  input  logic                         mul_e,
  input  logic [1:0]                   pcSrc,
  output logic [NSRC-1:0][1:0]         forward,
  output logic                         stallF,
  output logic                         stallD,
  output logic                         flushD,
  output logic                         flushE,
  output logic                         branchTaken,
  output logic                         mul_wb,
  output logic [REG_AW-1:0]            mul_rd
);
  state_e state;
  logic [2**REG_AW-1:0] pending;
  logic ld_stall, sb_stall;
  mul_tracker #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) u_trk (
    .clk(clk), .reset(reset), .mul_e(mul_e), .rd_e(rd_e), .regWrite_W(regWrite_W),
    .state(state), .pending(pending), .mul_rd(mul_rd), .mul_wb(mul_wb)
  );
  // per-port forward select and stall detection; the multiplier result beats M and W
  always_comb begin
    forward = '0;
    ld_stall = 1'b0;
    sb_stall = (regWrite_D && pending[rd_d]) || (mul_d && (state != IDLE || mul_e));
    for (int i = 0; i < NSRC; i++) begin
      forward[i] = (src_e_vld[i] && mul_wb && mul_rd == src_e[i]) ? FWD_MUL :
                   (regWrite_M && rd_m == src_e[i]) ? FWD_M :
                   (regWrite_W && rd_w == src_e[i]) ? FWD_W : FWD_RF;
      ld_stall = ld_stall || (src_d_vld[i] && resultSrc_E == RESULT_LOAD && src_d[i] == rd_e);
      sb_stall = sb_stall || (src_d_vld[i] && (pending[src_d[i]] || (mul_e && src_d[i] == rd_e)));
    end
  end
  assign branchTaken = pcSrc != 2'b00;
  assign stallF = (ld_stall || sb_stall) && !branchTaken;
  assign stallD = stallF;
  assign flushD = branchTaken;
  assign flushE = ld_stall || sb_stall || branchTaken;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table, directed multiply sequences and random model check
module tb_hazard_scoreboard;
  localparam int MUL_LAT = 3;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0][3:0] src_d, src_e;
  logic [1:0] src_d_vld, src_e_vld;
  logic [3:0] rd_d, rd_e, rd_m, rd_w;
  logic regWrite_D, regWrite_M, regWrite_W;
  logic [1:0] resultSrc_E, pcSrc;
  logic mul_d, mul_e;
  logic [1:0][1:0] forward;
  logic stallF, stallD, flushD, flushE, branchTaken, mul_wb;
  logic [3:0] mul_rd;
  int tests = 0, fails = 0;
  // reference model: whether a multiply is in flight, BUSY cycles left, its destination
  logic m_active = 1'b0;
  int m_left = 0;
  logic [3:0] m_rd = '0;

  typedef struct packed {
    logic [7:0] sd; logic [1:0] sdv; logic [7:0] se; logic [1:0] sev;
    logic [15:0] rds; logic [2:0] wr; logic [1:0] rs, pc; logic md, me;
    logic [3:0] fwd; logic [4:0] ctl;
  } vec_t;
  vec_t tbl[$];

  hazard_scoreboard #(.REG_AW(4), .NSRC(2), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .src_d(src_d), .src_e(src_e), .src_d_vld(src_d_vld),
    .src_e_vld(src_e_vld), .rd_d(rd_d), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regWrite_D(regWrite_D), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
    .resultSrc_E(resultSrc_E), .mul_d(mul_d), .mul_e(mul_e), .pcSrc(pcSrc),
    .forward(forward), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .branchTaken(branchTaken), .mul_wb(mul_wb), .mul_rd(mul_rd)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] sd, input logic [1:0] sdv, input logic [7:0] se,
                              input logic [1:0] sev, input logic [15:0] rds, input logic [2:0] wr,
                              input logic [1:0] rs, pc, input logic md, me,
                              input logic [3:0] fwd, input logic [4:0] ctl);
    return {sd, sdv, se, sev, rds, wr, rs, pc, md, me, fwd, ctl};
  endfunction

  task automatic drive(input vec_t v);
    src_d = v.sd; src_d_vld = v.sdv; src_e = v.se; src_e_vld = v.sev;
    {rd_d, rd_e, rd_m, rd_w} = v.rds; {regWrite_D, regWrite_M, regWrite_W} = v.wr;
    resultSrc_E = v.rs; pcSrc = v.pc; mul_d = v.md; mul_e = v.me;
  endtask

  task automatic clear_inputs();
    drive('0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [13:0] model_exp();
    logic [3:0] f;
    logic ld, sb, bt, wb, st;
    wb = m_active && m_left == 0 && !regWrite_W;
    bt = pcSrc != 2'b00;
    ld = 1'b0;
    sb = (regWrite_D && m_active && rd_d == m_rd) || (mul_d && (m_active || mul_e));
    for (int i = 0; i < 2; i++) begin
      if (src_e_vld[i] && wb && m_rd == src_e[i]) f[i*2 +: 2] = 2'b11;
      else if (regWrite_M && rd_m == src_e[i]) f[i*2 +: 2] = 2'b10;
      else if (regWrite_W && rd_w == src_e[i]) f[i*2 +: 2] = 2'b01;
      else f[i*2 +: 2] = 2'b00;
      if (src_d_vld[i] && resultSrc_E == 2'b01 && src_d[i] == rd_e) ld = 1'b1;
      if (src_d_vld[i] && ((m_active && src_d[i] == m_rd) || (mul_e && src_d[i] == rd_e))) sb = 1'b1;
    end
    st = (ld || sb) && !bt;
    return {f, st, st, bt, ld || sb || bt, bt, wb, m_rd};
  endfunction

  task automatic check_model(input string name);
    #1;
    chk(name, {forward, stallF, stallD, flushD, flushE, branchTaken, mul_wb, mul_rd}, model_exp());
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_active && m_left == 0 && !regWrite_W) m_active = 1'b0;
    else if (m_active && m_left > 0) m_left--;
    else if (!m_active && mul_e) begin
      m_active = 1'b1;
      m_left = MUL_LAT;
      m_rd = rd_e;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_active = 1'b0;
    m_left = 0;
    m_rd = '0;
    check_model("in_reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    check_model("reset_model");
    chk("reset_outputs", {stallF, stallD, flushD, flushE, branchTaken, mul_wb, mul_rd}, 0);
    @(negedge clk);
    reset = 1'b1;
    // sd, sdv, se, sev, {rd_d,rd_e,rd_m,rd_w}, {wD,wM,wW}, rs, pc, md, me, fwd, {sF,sD,fD,fE,bt}
    tbl.push_back(mk(8'h30, 2'b10, 8'h00, 2'b00, 16'h0300, 3'b000, 2'b01, 2'b00, 0, 0, 4'b0000, 5'b11010));
    tbl.push_back(mk(8'h30, 2'b01, 8'h00, 2'b00, 16'h0300, 3'b000, 2'b01, 2'b00, 0, 0, 4'b0000, 5'b00000));
    tbl.push_back(mk(8'h30, 2'b10, 8'h00, 2'b00, 16'h0300, 3'b000, 2'b10, 2'b00, 0, 0, 4'b0000, 5'b00000));
    tbl.push_back(mk(8'h00, 2'b00, 8'h95, 2'b11, 16'h0055, 3'b011, 2'b00, 2'b00, 0, 0, 4'b0010, 5'b00000));
    tbl.push_back(mk(8'h00, 2'b00, 8'h95, 2'b11, 16'h0055, 3'b001, 2'b00, 2'b00, 0, 0, 4'b0001, 5'b00000));
    tbl.push_back(mk(8'h00, 2'b00, 8'h64, 2'b11, 16'h0046, 3'b011, 2'b00, 2'b00, 0, 0, 4'b0110, 5'b00000));
    tbl.push_back(mk(8'h00, 2'b00, 8'h44, 2'b11, 16'h0040, 3'b000, 2'b00, 2'b00, 0, 0, 4'b0000, 5'b00000));
    tbl.push_back(mk(8'h00, 2'b00, 8'h11, 2'b00, 16'h0011, 3'b011, 2'b00, 2'b00, 0, 0, 4'b1010, 5'b00000));
    tbl.push_back(mk(8'h30, 2'b10, 8'h00, 2'b00, 16'h0300, 3'b000, 2'b01, 2'b01, 0, 0, 4'b0000, 5'b00111));
    tbl.push_back(mk(8'h00, 2'b00, 8'h00, 2'b00, 16'h0000, 3'b000, 2'b00, 2'b11, 0, 0, 4'b0000, 5'b00111));
    tbl.push_back(mk(8'h00, 2'b00, 8'h00, 2'b00, 16'h0000, 3'b000, 2'b00, 2'b00, 1, 0, 4'b0000, 5'b00000));
    tbl.push_back(mk(8'h00, 2'b00, 8'h00, 2'b00, 16'h5000, 3'b100, 2'b00, 2'b00, 0, 0, 4'b0000, 5'b00000));
    tbl.push_back(mk(8'h07, 2'b01, 8'h00, 2'b00, 16'h0700, 3'b000, 2'b00, 2'b00, 0, 1, 4'b0000, 5'b11010));
    tbl.push_back(mk(8'h00, 2'b00, 8'h00, 2'b00, 16'h0000, 3'b000, 2'b00, 2'b00, 1, 1, 4'b0000, 5'b11010));
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k]);
      #1;
      chk($sformatf("vec%0d", k), {forward, stallF, stallD, flushD, flushE, branchTaken, mul_wb},
          {tbl[k].fwd, tbl[k].ctl, 1'b0});
      @(negedge clk);
    end
    clear_inputs();
    do_reset();

    // multiply to r7: dependent decode stalls through BUSY and DONE, result forwarded in DONE
    mul_e = 1'b1; rd_e = 4'd7;
    check_model("mul7_issue");
    tick();
    mul_e = 1'b0; rd_e = 4'd0; src_d[0] = 4'd7; src_d_vld = 2'b01;
    for (int k = 0; k < MUL_LAT; k++) begin
      check_model("mul7_busy");
      chk("mul7_busy_stall", stallD, 1);
      chk("mul7_busy_wb", mul_wb, 0);
      tick();
    end
    src_e[0] = 4'd7; src_e_vld = 2'b01;
    check_model("mul7_done");
    chk("mul7_done_wb", mul_wb, 1);
    chk("mul7_done_rd", mul_rd, 7);
    chk("mul7_done_fwd", forward[0], 2'b11);
    tick();
    check_model("mul7_idle");
    chk("mul7_idle_stall", stallD, 0);
    chk("mul7_idle_wb", mul_wb, 0);

    // multiply to r2 with a branch in BUSY and a two-cycle writeback-port conflict in DONE
    clear_inputs();
    mul_e = 1'b1; rd_e = 4'd2;
    check_model("mul2_issue");
    tick();
    mul_e = 1'b0; rd_e = 4'd0; src_d[0] = 4'd2; src_d_vld = 2'b01; pcSrc = 2'b01;
    check_model("mul2_branch");
    chk("mul2_branch_flush", {flushD, flushE, stallD, stallF}, 4'b1100);
    tick();
    pcSrc = 2'b00;
    for (int k = 1; k < MUL_LAT; k++) begin
      check_model("mul2_busy");
      tick();
    end
    regWrite_W = 1'b1; rd_w = 4'd9;
    for (int k = 0; k < 2; k++) begin
      check_model("mul2_conflict");
      chk("mul2_conflict_wb", mul_wb, 0);
      chk("mul2_conflict_stall", stallD, 1);
      tick();
    end
    regWrite_W = 1'b0;
    check_model("mul2_wb");
    chk("mul2_wb_pulse", mul_wb, 1);
    tick();
    check_model("mul2_after");
    chk("mul2_after_stall", stallD, 0);

    // reset in BUSY abandons the multiply
    clear_inputs();
    mul_e = 1'b1; rd_e = 4'd5;
    check_model("mul5_issue");
    tick();
    mul_e = 1'b0; rd_e = 4'd0; src_d[0] = 4'd5; src_d_vld = 2'b01;
    check_model("mul5_busy");
    chk("mul5_busy_stall", stallD, 1);
    do_reset();
    chk("mul5_reset_stall", stallD, 0);
    for (int k = 0; k < MUL_LAT + 3; k++) begin
      check_model("mul5_after");
      chk("mul5_no_wb", mul_wb, 0);
      tick();
    end

    // random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        src_d[i] = 4'($urandom_range(0, 3));
        src_e[i] = 4'($urandom_range(0, 3));
      end
      src_d_vld = 2'($urandom); src_e_vld = 2'($urandom);
      rd_d = 4'($urandom_range(0, 3)); rd_e = 4'($urandom_range(0, 3));
      rd_m = 4'($urandom_range(0, 3)); rd_w = 4'($urandom_range(0, 3));
      regWrite_D = 1'($urandom); regWrite_M = 1'($urandom); regWrite_W = 1'($urandom);
      resultSrc_E = 2'($urandom);
      mul_d = $urandom_range(0, 5) == 0;
      mul_e = $urandom_range(0, 3) == 0;
      pcSrc = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      check_model($sformatf("rand%0d", n));
      if (n % 300 == 299) do_reset();
      else tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 4, meaning register-address width (NREGS = 2**REG_AW).
REQ-002 SHALL have parameter NSRC, default 2, meaning number of source-operand ports per instruction (1..4).
REQ-003 SHALL have parameter MUL_LAT, default 3, meaning multiply execute cycles (2..15).
REQ-004 SHALL have port clk, input, 1, meaning the only clock; all state on the rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports src_d and src_e, input, NSRC x REG_AW, meaning Decode and Execute source registers; src_d_vld and src_e_vld, input, NSRC, meaning per-port valid.
REQ-007 SHALL have ports rd_d, rd_e, rd_m, rd_w, input, REG_AW, meaning destinations; regWrite_D, regWrite_M, regWrite_W, input, 1, meaning write enables.
REQ-008 SHALL have ports resultSrc_E, input, 2, meaning 01 = load in Execute; mul_d and mul_e, input, 1, meaning a multiply in Decode or Execute.
REQ-009 SHALL have port pcSrc, input, 2, meaning a non-zero value redirects the PC.
REQ-010 SHALL have output forward, NSRC x 2, meaning per-port select: 00 register file, 01 W, 10 M, 11 multiplier result.
REQ-011 SHALL have outputs stallF, stallD, flushD, flushE, branchTaken, mul_wb, 1 each, and mul_rd, REG_AW.

Function
REQ-012 SHALL drive branchTaken = (pcSrc != 00), combinationally.
REQ-013 SHALL compute forward[i] = 11 if src_e_vld[i] and mul_wb and mul_rd == src_e[i]; else 10 if regWrite_M and rd_m match; else 01 if regWrite_W and rd_w match; else 00.
REQ-014 SHALL raise ldStall when resultSrc_E == 01 and any valid src_d[i] == rd_e.
REQ-015 SHALL raise sbStall when any valid src_d[i] equals a pending register, or equals rd_e while mul_e = 1.
REQ-016 SHALL raise sbStall on a WAW hazard: regWrite_D and rd_d equals a pending register.
REQ-017 SHALL raise sbStall on a structural hazard: mul_d = 1 while the FSM is not IDLE, or while mul_e = 1.
REQ-018 SHALL drive stallF = stallD = ldStall or sbStall.
REQ-019 SHALL drive flushE = ldStall or sbStall or branchTaken, and flushD = branchTaken.
REQ-020 SHALL give branchTaken priority: when branchTaken = 1, stallF and stallD SHALL be 0 and flushD and flushE SHALL be 1.
REQ-021 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE with a down-counter.
REQ-022 IDLE with mul_e = 1: SHALL capture rd_e into mul_rd, set its pending bit, load the counter with MUL_LAT-1, and go to BUSY.
REQ-023 BUSY: SHALL decrement the counter each cycle and go to DONE when the counter reaches 0.
REQ-024 DONE: SHALL assert mul_wb for one cycle only when regWrite_W = 0, then clear the pending bit and go to IDLE.
REQ-025 DONE with regWrite_W = 1: SHALL hold in DONE with mul_wb = 0 (writeback-port conflict).
REQ-026 SHALL allow at most one multiply outstanding; mul_e in a state other than IDLE is impossible by REQ-017 and SHALL be ignored.
REQ-027 SHALL hold the pending vector (NREGS bits, one-hot or zero) and the counter without wrap; the counter SHALL never decrement below 0.

Reset
REQ-028 On reset low, SHALL asynchronously set FSM = IDLE, counter = 0, pending = 0 and mul_rd = 0, so mul_wb = 0 and no scoreboard stall remains.
REQ-029 A reset during BUSY or DONE SHALL abandon the multiply with no mul_wb pulse.
REQ-030 After reset release, SHALL resume in IDLE on the next rising edge.

Structure
REQ-031 A shared package SHALL hold the forward-select enum (FWD_RF, FWD_W, FWD_M, FWD_MUL), the FSM state enum and the constant RESULT_LOAD = 2'b01.
REQ-032 SHALL contain one sub-module, mul_tracker, holding the FSM, counter, pending vector and mul_rd; all stall, flush and forward logic SHALL be combinational in the top.

Verification
REQ-033 Load-use: resultSrc_E = 01, rd_e = 3, src_d[1] = 3 -> stallF = stallD = flushE = 1 for one cycle.
REQ-034 Forward priority: rd_m = rd_w = 5, both writing, src_e[0] = 5 -> forward[0] = 10; with regWrite_M = 0 -> 01.
REQ-035 Multiply with MUL_LAT = 3: mul_e with rd_e = 7 -> BUSY for 3 cycles; a dependent src_d = 7 stalls until the DONE cycle; mul_wb = 1 with mul_rd = 7; forward = 11 when src_e = 7.
REQ-036 Writeback conflict: regWrite_W held 1 for 2 cycles in DONE -> mul_wb is delayed 2 cycles and pending stays set until mul_wb.
REQ-037 Branch during scoreboard stall: pcSrc = 01 -> flushD = flushE = 1 and stallD = 0.
REQ-038 Reset pulse in BUSY -> pending = 0, IDLE, and no mul_wb afterwards.
